flt: RTL and testbench
======================

FLT -- requirements
Module: flt

Interface
REQ-001 The module SHALL have no parameters; the operand format is fixed to IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 x1  input  32  left operand, binary32 bit pattern {sign, exp[7:0], frac[22:0]}.
REQ-005 x2  input  32  right operand, same format.
REQ-006 in_valid  input  1  operands on x1/x2 are valid this cycle.
REQ-007 v  output  32-bit-free 1  registered result: 1 when x1 <= x2 numerically, else 0.
REQ-008 out_valid  output  1  v holds the result of the operands sampled on the previous valid cycle.

Function
REQ-009 The block SHALL compute v = (x1 <= x2) under IEEE-754 ordered-compare semantics, combinationally from x1/x2, and register it.
REQ-010 Latency SHALL be exactly 1 clock: operands sampled at edge N with in_valid=1 produce v and out_valid=1 after edge N.
REQ-011 A cycle with in_valid=0 SHALL drive out_valid=0 after the next edge; v SHALL hold its previous value.
REQ-012 Back-to-back valid operands SHALL be accepted every cycle; there is no backpressure.
REQ-013 Zero: magnitude (bits 30:0) equal to 0 is zero regardless of sign; +0 <= -0 and -0 <= +0 SHALL both give v=1.
REQ-014 Signs differ, not both zero: v SHALL equal sign of x1 (negative <= positive is 1, positive <= negative is 0).
REQ-015 Both positive: v SHALL be 1 iff unsigned x1[30:0] <= x2[30:0].
REQ-016 Both negative: v SHALL be 1 iff unsigned x1[30:0] >= x2[30:0].
REQ-017 Subnormals (exp=0, frac!=0) SHALL be compared at full value, not flushed to zero.
REQ-018 Equal bit patterns (non-NaN) SHALL give v=1.
REQ-019 Infinities (exp=255, frac=0) SHALL order as the extreme values by REQ-014..016.
REQ-020 NaN (exp=255, frac!=0) on either operand SHALL give v=0.
REQ-021 No internal state beyond the v and out_valid registers SHALL exist.

Reset
REQ-022 While rst=1 at a rising edge, v SHALL become 0 and out_valid SHALL become 0, regardless of in_valid.
REQ-023 Operands presented with in_valid=1 in the same cycle as rst=1 SHALL be discarded.
REQ-024 The first valid operands after rst deasserts SHALL produce a result one edge later per REQ-010.

Verification
REQ-025 x1=0x3F800000 (1.0), x2=0x40000000 (2.0), in_valid=1 -> next cycle v=1, out_valid=1; swapped -> v=0.
REQ-026 x1=0x80000000 (-0), x2=0x00000000 (+0) -> v=1; swapped -> v=1; x1=x2=0xC0490FDB -> v=1.
REQ-027 x1=0xBF800000 (-1.0), x2=0xC0000000 (-2.0) -> v=0; x1=0x00000001, x2=0x00000002 (subnormals) -> v=1; x1=0x80000001, x2=0x00000000 -> v=1.
REQ-028 x1=0x7FC00000 (NaN), x2=0x3F800000 -> v=0; x1=0xFF800000 (-inf), x2=0x7F7FFFFF -> v=1.
REQ-029 Stream of valid operands each cycle, then assert rst mid-stream -> after that edge v=0, out_valid=0; results resume one cycle after rst drops.
REQ-030 Sweep: exponents 0..254 for both operands, both signs, fractions {0, 1, 2, 0x380000, 0x400000, 0x5FFFFF, 0x7FFFFF, random}, plus equal-exponent pairs sharing random upper fraction bits -> v matches a real-valued x1 <= x2 reference every cycle.

Source files
------------

// File: rtl/flt.sv
// Registered IEEE-754 binary32 ordered compare: v = (x1 <= x2), one-cycle latency.
// A NaN operand yields 0, and zeros of either sign compare equal.
module flt (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        in_valid,
  output logic        v,
  output logic        out_valid
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;

  function automatic logic is_nan(input logic [DATA_W-1:0] a);
    return (a[DATA_W-2 -: EXP_W] == {EXP_W{1'b1}}) && (a[FRAC_W-1:0] != '0);
  endfunction

  // Sign-magnitude ordering: a larger magnitude is greater when positive and
  // smaller when negative. Infinities and subnormals fall out of the raw bits.
  function automatic logic le_f32(input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] b);
    logic [DATA_W-2:0] ma;
    logic [DATA_W-2:0] mb;
    logic              res;
    ma = a[DATA_W-2:0];
    mb = b[DATA_W-2:0];
    if (is_nan(a) || is_nan(b))
      res = 1'b0;
    else if ((ma == '0) && (mb == '0))
      res = 1'b1;
    else if (a[DATA_W-1] != b[DATA_W-1])
      res = a[DATA_W-1];
    else if (!a[DATA_W-1])
      res = (ma <= mb);
    else
      res = (ma >= mb);
    return res;
  endfunction

  logic cmp_p0;
  logic v_d, v_q;
  logic out_valid_d, out_valid_q;

  assign cmp_p0 = le_f32(x1, x2);

  always_comb begin
    v_d         = v_q;
    out_valid_d = in_valid;
    if (in_valid) v_d = cmp_p0;
  end

  // Stage p0 -> p1: result register
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign v         = v_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_flt.sv
// Self-checking bench for flt: table vectors, reset/hold sequences and a
// sweep checked against a real-valued reference through a scoreboard queue.
module tb_flt;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        in_valid;
  logic        v;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;
  bit sb[$];
  bit last_v   = 1'b0;

  flt dut (
    .clk       (clk),
    .rst       (rst),
    .x1        (x1),
    .x2        (x2),
    .in_valid  (in_valid),
    .v         (v),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    bit          exp_v;
  } vec_t;

  function automatic real to_real(input logic [31:0] f);
    int unsigned mant;
    int          e;
    real         r;
    if (f[30:23] == 8'hFF) return f[31] ? -1.0e300 : 1.0e300;
    mant = (f[30:23] == 8'd0) ? {9'd0, f[22:0]} : {8'd0, 1'b1, f[22:0]};
    e    = (f[30:23] == 8'd0) ? 1 : int'(f[30:23]);
    r    = real'(mant) * (2.0 ** (e - 150));
    return f[31] ? -r : r;
  endfunction

  function automatic bit ref_le(input logic [31:0] a, input logic [31:0] b);
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
      return 1'b0;
    return to_real(a) <= to_real(b);
  endfunction

  task automatic step(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic vld, input logic r, input bit use_exp, input bit expv);
    bit exp_v;
    bit exp_ov;
    x1 = a; x2 = b; in_valid = vld; rst = r;
    if (vld && !r) sb.push_back(use_exp ? expv : ref_le(a, b));
    @(posedge clk);
    #1;
    exp_ov = vld && !r;
    if (r)                         exp_v = 1'b0;
    else if (vld && sb.size() > 0) exp_v = sb.pop_front();
    else                           exp_v = last_v;
    checks++;
    if (v !== exp_v || out_valid !== exp_ov) begin
      failures++;
      $display("FAIL %s: a=%h b=%h got v=%b out_valid=%b, expected v=%b out_valid=%b",
               name, a, b, v, out_valid, exp_v, exp_ov);
    end
    last_v = exp_v;
  endtask

  vec_t tab[12];
  logic [22:0] fr[8];

  initial begin
    logic [31:0] a, b;
    logic [22:0] fa, fb, hi;
    int          e2;

    tab[0]  = '{"1<=2",        32'h3F800000, 32'h40000000, 1'b1};
    tab[1]  = '{"2<=1",        32'h40000000, 32'h3F800000, 1'b0};
    tab[2]  = '{"-0<=+0",      32'h80000000, 32'h00000000, 1'b1};
    tab[3]  = '{"+0<=-0",      32'h00000000, 32'h80000000, 1'b1};
    tab[4]  = '{"eq_neg_pi",   32'hC0490FDB, 32'hC0490FDB, 1'b1};
    tab[5]  = '{"-1<=-2",      32'hBF800000, 32'hC0000000, 1'b0};
    tab[6]  = '{"sub1<=sub2",  32'h00000001, 32'h00000002, 1'b1};
    tab[7]  = '{"-sub<=+0",    32'h80000001, 32'h00000000, 1'b1};
    tab[8]  = '{"nan<=1",      32'h7FC00000, 32'h3F800000, 1'b0};
    tab[9]  = '{"-inf<=max",   32'hFF800000, 32'h7F7FFFFF, 1'b1};
    tab[10] = '{"1<=nan",      32'h3F800000, 32'h7FC00001, 1'b0};
    tab[11] = '{"+inf<=+inf",  32'h7F800000, 32'h7F800000, 1'b1};

    fr[0] = 23'd0;       fr[1] = 23'd1;       fr[2] = 23'd2;       fr[3] = 23'h380000;
    fr[4] = 23'h400000;  fr[5] = 23'h5FFFFF;  fr[6] = 23'h7FFFFF;  fr[7] = 23'd0;

    // Reset, with valid operands presented that must be discarded
    step("reset", 32'h3F800000, 32'h40000000, 1'b1, 1'b1, 1'b0, 1'b0);
    step("reset2", 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++)
      step(tab[i].name, tab[i].a, tab[i].b, 1'b1, 1'b0, 1'b1, tab[i].exp_v);

    // Hold: v keeps its last value while in_valid is low
    step("set_one", 32'h3F800000, 32'h40000000, 1'b1, 1'b0, 1'b1, 1'b1);
    step("hold1", 32'h40000000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hold2", 32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0);
    step("set_zero", 32'h40000000, 32'h3F800000, 1'b1, 1'b0, 1'b1, 1'b0);
    step("hold3", 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stream, reset mid-stream, then resume
    step("stream0", 32'h3F800000, 32'h40000000, 1'b1, 1'b0, 1'b1, 1'b1);
    step("stream1", 32'h00000001, 32'h00000002, 1'b1, 1'b0, 1'b1, 1'b1);
    step("stream2", 32'hBF800000, 32'hBF800000, 1'b1, 1'b0, 1'b1, 1'b1);
    step("mid_rst", 32'h3F800000, 32'h40000000, 1'b1, 1'b1, 1'b0, 1'b0);
    step("resume0", 32'hFF800000, 32'h7F7FFFFF, 1'b1, 1'b0, 1'b1, 1'b1);
    step("resume1", 32'h40000000, 32'h3F800000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Sweep against the real-valued reference
    for (int e = 0; e < 255; e++) begin
      for (int k = 0; k < 8; k++) begin
        fa = (k == 7) ? 23'($urandom_range(0, 32'h7FFFFF)) : fr[k];
        fb = ($urandom_range(0, 3) == 0) ? 23'($urandom_range(0, 32'h7FFFFF)) : fr[(k + 3) % 8];
        e2 = (k % 2 == 1) ? e : int'($urandom_range(0, 254));
        a  = {1'($urandom_range(0, 1)), 8'(e),  fa};
        b  = {1'($urandom_range(0, 1)), 8'(e2), fb};
        step("sweep", a, b, 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end

    // Equal exponents sharing random upper fraction bits
    for (int n = 0; n < 400; n++) begin
      e2 = int'($urandom_range(0, 254));
      hi = 23'($urandom_range(0, 32'h7FFFFF));
      fa = {hi[22:6], 6'($urandom_range(0, 63))};
      fb = {hi[22:6], 6'($urandom_range(0, 63))};
      a  = {1'($urandom_range(0, 1)), 8'(e2), fa};
      b  = (n % 5 == 0) ? a : {1'($urandom_range(0, 1)), 8'(e2), fb};
      step("eqexp", a, b, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    in_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
